// File: rtl/msrv32_dmem_responder.sv
// Data-memory slave for the core: word-addressed RAM plus a memory-mapped machine timer
// (mtime/mtimecmp/msip) with registered read data and an unmapped-access error pulse.
module msrv32_dmem_responder #(
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] TIMER_BASE      = 32'hFFFF_FF00,
  parameter int unsigned PRESCALE        = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [63:0] ms_riscv32_mp_rc_out,
  output logic        ms_riscv32_mp_tirq_out,
  output logic        ms_riscv32_mp_sirq_out,
  output logic        dm_err_out
);

  localparam int unsigned AW = $clog2(MEM_DEPTH_WORDS);

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [3:0]  mask;

  assign clk   = ms_riscv32_mp_clk_in;
  assign rst   = ms_riscv32_mp_rst_in;
  assign addr  = ms_riscv32_mp_dmaddr_in;
  assign wdata = ms_riscv32_mp_dmdata_in;
  assign wr    = ms_riscv32_mp_dmwr_req_in;
  assign mask  = ms_riscv32_mp_dmwr_mask_in;

  logic [31:0]   mem [MEM_DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [5:0]    tmr_off;
  logic          ram_hit;
  logic          tmr_win;
  logic          unmapped;

  logic [31:0] rdata_q, rdata_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic        msip_q, msip_d;
  logic        tirq_q, tirq_d;
  logic        err_q, err_d;
  logic        tick;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  en);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign word_idx = addr[AW+1:2];
  assign tmr_off  = addr[7:2];
  assign ram_hit  = (addr[31:AW+2] == '0);
  assign tmr_win  = (addr[31:8] == TIMER_BASE[31:8]);
  assign unmapped = !ram_hit && !(tmr_win && (tmr_off <= 6'd4));
  assign tick     = (pre_cnt_q == 16'(PRESCALE - 1));

  always_comb begin
    rdata_d    = 32'h0;
    pre_cnt_d  = tick ? 16'h0 : pre_cnt_q + 16'h1;
    mtime_d    = tick ? mtime_q + 64'h1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    err_d      = unmapped;

    // Reads see pre-edge contents, giving read-first behaviour everywhere.
    if (ram_hit) begin
      rdata_d = mem[word_idx];
    end else if (tmr_win) begin
      case (tmr_off)
        6'd0:    rdata_d = mtime_q[31:0];
        6'd1:    rdata_d = mtime_q[63:32];
        6'd2:    rdata_d = mtimecmp_q[31:0];
        6'd3:    rdata_d = mtimecmp_q[63:32];
        6'd4:    rdata_d = {31'h0, msip_q};
        default: rdata_d = 32'h0;
      endcase
    end

    // An mtime write overrides the increment and restarts the prescaler.
    if (wr && !ram_hit && tmr_win) begin
      case (tmr_off)
        6'd0: begin
          mtime_d   = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wdata, mask)};
          pre_cnt_d = 16'h0;
        end
        6'd1: begin
          mtime_d   = {merge_lanes(mtime_q[63:32], wdata, mask), mtime_q[31:0]};
          pre_cnt_d = 16'h0;
        end
        6'd2: mtimecmp_d = {mtimecmp_q[63:32], merge_lanes(mtimecmp_q[31:0], wdata, mask)};
        6'd3: mtimecmp_d = {merge_lanes(mtimecmp_q[63:32], wdata, mask), mtimecmp_q[31:0]};
        6'd4: if (mask[0]) msip_d = wdata[0];
        default: ;
      endcase
    end

    tirq_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= 32'h0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= '1;
      pre_cnt_q  <= 16'h0;
      msip_q     <= 1'b0;
      tirq_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pre_cnt_q  <= pre_cnt_d;
      msip_q     <= msip_d;
      tirq_q     <= tirq_d;
      err_q      <= err_d;
    end
  end

  // RAM has no reset; a store coinciding with reset assertion is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && wr && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign ms_riscv32_mp_dmdata_out = rdata_q;
  assign ms_riscv32_mp_rc_out     = mtime_q;
  assign ms_riscv32_mp_tirq_out   = tirq_q;
  assign ms_riscv32_mp_sirq_out   = msip_q;
  assign dm_err_out               = err_q;

endmodule
